// File: rtl/serial_string_recognizer.sv
// Serial receiver: rebuilds MSB-first framed words from a bit stream and flags every
// (overlapping) occurrence of a programmable pattern, keeping a saturating match count.
module serial_string_recognizer #(
  parameter int unsigned      WIDTH   = 4,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [WIDTH-1:0] RST_PAT = WIDTH'(4'b0110)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic [WIDTH-1:0] pat,
  input  logic             pat_load,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int unsigned FillW  = $clog2(WIDTH + 1);
  localparam int unsigned FrameW = $clog2(WIDTH);

  localparam logic [FillW-1:0]  FillFull  = FillW'(WIDTH);
  localparam logic [FrameW-1:0] FrameLast = FrameW'(WIDTH - 1);
  localparam logic [CNT_W-1:0]  CntMax    = '1;

  if (WIDTH < 2) begin : g_width_check
    $error("serial_string_recognizer: WIDTH must be at least 2");
  end

  typedef enum logic [0:0] {StFill, StArmed} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   window_q, window_d;
  logic [WIDTH-1:0]   pattern_q, pattern_d;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [FrameW-1:0]  frame_q, frame_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    pattern_d    = pattern_q;
    fill_d       = fill_q;
    frame_d      = frame_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    match_d      = 1'b0;

    if (pat_load) begin
      // Reload restarts detection; a bit offered in the same cycle is dropped.
      pattern_d = pat;
      window_d  = '0;
      fill_d    = '0;
      frame_d   = '0;
      state_d   = StFill;
    end else if (din_valid) begin
      window_d = {window_q[WIDTH-2:0], din};

      if (fill_q != FillFull) begin
        fill_d = fill_q + FillW'(1);
      end

      if (fill_d == FillFull) begin
        state_d = StArmed;
        match_d = (window_d == pattern_q);
      end

      if (frame_q == FrameLast) begin
        frame_d      = '0;
        word_d       = window_d;
        word_valid_d = 1'b1;
      end else begin
        frame_d = frame_q + FrameW'(1);
      end
    end
  end

  // Clear beats a coincident match; the pulse itself is still emitted.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match_d && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFill;
      window_q     <= '0;
      pattern_q    <= RST_PAT;
      fill_q       <= '0;
      frame_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      match_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      pattern_q    <= pattern_d;
      fill_q       <= fill_d;
      frame_q      <= frame_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      match_q      <= match_d;
      cnt_q        <= cnt_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign match      = match_q;
  assign match_cnt  = cnt_q;
  assign armed      = (state_q == StArmed);

endmodule

// File: tb/tb_serial_string_recognizer.sv
// Scoreboard bench: a bit-history reference model predicts pulses; a monitor checks them.
module tb_serial_string_recognizer;

  localparam int W  = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          din = 1'b0;
  logic          din_valid = 1'b0;
  logic [W-1:0]  pat = '0;
  logic          pat_load = 1'b0;
  logic          cnt_clr = 1'b0;
  logic [W-1:0]  word;
  logic          word_valid;
  logic          match;
  logic [CW-1:0] match_cnt;
  logic          armed;

  always #5 clk = ~clk;

  serial_string_recognizer #(
    .WIDTH  (W),
    .CNT_W  (CW),
    .RST_PAT(4'b0110)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .pat       (pat),
    .pat_load  (pat_load),
    .cnt_clr   (cnt_clr),
    .word      (word),
    .word_valid(word_valid),
    .match     (match),
    .match_cnt (match_cnt),
    .armed     (armed)
  );

  typedef struct {
    int            cyc;
    logic          m;
    logic          wv;
    logic [W-1:0]  w;
    logic [CW-1:0] c;
    logic          a;
  } ev_t;

  ev_t exp_q[$];

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: the raw list of bits accepted since the last restart.
  logic          m_bits[$];
  logic [W-1:0]  m_pat = 4'b0110;
  logic [CW-1:0] m_cnt = '0;
  logic [W-1:0]  m_word = '0;
  logic          m_armed = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pl, input logic [W-1:0] p,
                       input logic dv, input logic d, input logic clr);
    logic         exp_m;
    logic         exp_wv;
    int           n;
    int           v;
    int           cmax;
    ev_t          e;
    rst = r; pat_load = pl; pat = p; din_valid = dv; din = d; cnt_clr = clr;
    exp_m  = 1'b0;
    exp_wv = 1'b0;
    cmax   = (1 << CW) - 1;
    if (r) begin
      m_bits.delete();
      m_pat  = 4'b0110;
      m_cnt  = '0;
      m_word = '0;
    end else begin
      if (pl) begin
        m_pat = p;
        m_bits.delete();
      end else if (dv) begin
        m_bits.push_back(d);
        n = m_bits.size();
        if (n >= W) begin
          v = 0;
          for (int i = n - W; i < n; i++) v = v * 2 + int'(m_bits[i]);
          if (v == int'(m_pat)) exp_m = 1'b1;
          if (n % W == 0) begin
            exp_wv = 1'b1;
            m_word = W'(v);
          end
        end
      end
      if (clr) m_cnt = '0;
      else if (exp_m && int'(m_cnt) < cmax) m_cnt = m_cnt + 1'b1;
    end
    m_armed = (m_bits.size() >= W);
    if (exp_m || exp_wv) begin
      e.cyc = cyc + 1; e.m = exp_m; e.wv = exp_wv; e.w = m_word; e.c = m_cnt; e.a = m_armed;
      exp_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic bit_in(input logic d);
    drive(1'b0, 1'b0, '0, 1'b1, d, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_rst();
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
  endtask

  task automatic chk_state(input string tag);
    check({tag, "_armed"}, int'(armed), int'(m_armed));
    check({tag, "_match_cnt"}, int'(match_cnt), int'(m_cnt));
    check({tag, "_word"}, int'(word), int'(m_word));
  endtask

  // Monitor: every pulse the DUT presents must match the oldest predicted event.
  always @(negedge clk) begin
    if (cyc >= 1 && (match !== 1'b0 || word_valid !== 1'b0)) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pulse at cycle %0d: match=%b word_valid=%b, expected none",
                 cyc, match, word_valid);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("event_cycle", cyc, e.cyc);
        check("event_match", int'(match), int'(e.m));
        check("event_word_valid", int'(word_valid), int'(e.wv));
        check("event_match_cnt", int'(match_cnt), int'(e.c));
        check("event_armed", int'(armed), int'(e.a));
        if (e.wv) check("event_word", int'(word), int'(e.w));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Reset for two cycles, then a single 0110.
    do_rst();
    do_rst();
    check("rst_match", int'(match), 0);
    check("rst_word_valid", int'(word_valid), 0);
    chk_state("rst");
    feed(16'b0110, 4);
    chk_state("first_pattern");
    check("first_pattern_armed_hi", int'(armed), 1);
    idle();

    // Overlapping occurrences, then one extra bit to complete the second frame.
    do_rst();
    feed(16'b0110110, 7);
    chk_state("overlap");
    bit_in(1'b1);
    chk_state("overlap_frame2");
    idle();

    // Gapped input.
    do_rst();
    feed(16'b01, 2);
    for (int i = 0; i < 5; i++) idle();
    feed(16'b10, 2);
    chk_state("gapped");
    idle();

    // Mid-stream reload with a coincident (dropped) bit.
    feed(16'b10, 2);
    drive(1'b0, 1'b1, 4'b1010, 1'b1, 1'b1, 1'b0);
    chk_state("reload");
    check("reload_armed_lo", int'(armed), 0);
    feed(16'b101010, 6);
    chk_state("reload_stream");
    idle();

    // Counter saturation, then clear coincident with a match.
    do_rst();
    feed(16'b0110110110110110, 16);
    chk_state("saturate");
    feed(16'b11, 2);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    chk_state("clr_vs_match");
    idle();

    // Reset mid-stream restores the reset pattern and restarts fill.
    drive(1'b0, 1'b1, 4'b1001, 1'b0, 1'b0, 1'b0);
    feed(16'b011, 3);
    do_rst();
    bit_in(1'b0);
    chk_state("rst_mid");
    feed(16'b110, 3);
    chk_state("rst_mid_pattern");
    idle();

    // Randomized traffic; small alphabet keeps matches frequent.
    for (int i = 0; i < 3000; i++) begin
      logic r, pl, dv, d, clr;
      logic [W-1:0] p;
      r   = ($urandom_range(0, 299) == 0);
      pl  = ($urandom_range(0, 59) == 0);
      p   = W'($urandom);
      dv  = ($urandom_range(0, 9) < 7);
      d   = 1'($urandom);
      clr = ($urandom_range(0, 24) == 0);
      drive(r, pl, p, dv, d, clr);
      if (i % 100 == 99) chk_state("random");
    end

    idle();
    idle();
    check("pending_events", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
